// File: rtl/hazard_fwd_unit_pkg.sv
// Shared definitions for the hazard/forwarding unit: operand-select encoding and
// the per-stage tracking record.
package hazard_fwd_unit_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_ALU = 2'd1;
    localparam logic [1:0] FWD_DM  = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    // Tracked destination addresses are stored zero-extended to this width.
    localparam int TRK_AW = 8;

    typedef struct packed {
        logic              valid;
        logic [TRK_AW-1:0] rd;
        logic              we;
        logic              is_load;
    } stage_t;

    function automatic logic stage_match(input stage_t s, input logic [TRK_AW-1:0] src,
                                         input logic used, input logic r0_zero);
        return s.valid & s.we & used & (s.rd == src) & ~(r0_zero & (src == '0));
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_mux.sv
// Per-operand forwarding select: youngest writer wins (ALU > DM > WB), else RF.
module fwd_mux
    import hazard_fwd_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int FWD_EN = 1
) (
    input  logic            i_hit_alu,
    input  logic            i_hit_dm,
    input  logic            i_hit_wb,
    input  logic [XLEN-1:0] i_rf,
    input  logic [XLEN-1:0] i_alu,
    input  logic [XLEN-1:0] i_dm,
    input  logic [XLEN-1:0] i_wb,
    output logic [1:0]      o_sel,
    output logic [XLEN-1:0] o_data
);

    logic [1:0] w_sel;

    always_comb begin
        w_sel = FWD_RF;
        if (FWD_EN != 0) begin
            if (i_hit_alu)     w_sel = FWD_ALU;
            else if (i_hit_dm) w_sel = FWD_DM;
            else if (i_hit_wb) w_sel = FWD_WB;
        end
    end

    always_comb begin
        case (w_sel)
            FWD_ALU: o_data = i_alu;
            FWD_DM:  o_data = i_dm;
            FWD_WB:  o_data = i_wb;
            default: o_data = i_rf;
        endcase
    end

    assign o_sel = w_sel;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Data-hazard detection and operand forwarding for a 5-stage pipeline; tracks
// the ALU/DM/WB destinations and raises stall/bubble/flush combinationally.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int FWD_EN  = 1,
    parameter int R0_ZERO = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_id_valid,
    input  logic              i_id_rs1_used,
    input  logic              i_id_rs2_used,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic [REG_AW-1:0] i_id_rd,
    input  logic              i_id_we,
    input  logic              i_id_is_load,
    input  logic              i_br_taken,
    input  logic [XLEN-1:0]   i_rf_rd1,
    input  logic [XLEN-1:0]   i_rf_rd2,
    input  logic [XLEN-1:0]   i_ex_result,
    input  logic [XLEN-1:0]   i_mem_result,
    input  logic [XLEN-1:0]   i_wb_result,
    output logic [XLEN-1:0]   o_opa,
    output logic [XLEN-1:0]   o_opb,
    output logic [1:0]        o_fwd_a_sel,
    output logic [1:0]        o_fwd_b_sel,
    output logic              o_stall,
    output logic              o_bubble,
    output logic              o_flush_if,
    output logic [31:0]       o_stall_cnt
);

    localparam logic R0_HARD = (R0_ZERO != 0);

    stage_t            r_alu, r_dm, r_wb;
    logic [31:0]       r_stall_cnt;
    stage_t            w_alu_nxt;
    logic [TRK_AW-1:0] w_rs1, w_rs2;
    logic              w_a_alu, w_a_dm, w_a_wb;
    logic              w_b_alu, w_b_dm, w_b_wb;
    logic              w_load_use, w_any_hit, w_stall;

    // Matches are masked during reset so stale tracking state never forwards.
    always_comb begin
        w_rs1   = TRK_AW'(i_id_rs1);
        w_rs2   = TRK_AW'(i_id_rs2);
        w_a_alu = ~reset & stage_match(r_alu, w_rs1, i_id_rs1_used, R0_HARD);
        w_a_dm  = ~reset & stage_match(r_dm,  w_rs1, i_id_rs1_used, R0_HARD);
        w_a_wb  = ~reset & stage_match(r_wb,  w_rs1, i_id_rs1_used, R0_HARD);
        w_b_alu = ~reset & stage_match(r_alu, w_rs2, i_id_rs2_used, R0_HARD);
        w_b_dm  = ~reset & stage_match(r_dm,  w_rs2, i_id_rs2_used, R0_HARD);
        w_b_wb  = ~reset & stage_match(r_wb,  w_rs2, i_id_rs2_used, R0_HARD);

        w_load_use = r_alu.is_load & (w_a_alu | w_b_alu);
        w_any_hit  = w_a_alu | w_a_dm | w_a_wb | w_b_alu | w_b_dm | w_b_wb;
        w_stall    = i_id_valid & ((FWD_EN != 0) ? w_load_use : w_any_hit);

        w_alu_nxt.valid   = i_id_valid & ~w_stall;
        w_alu_nxt.rd      = TRK_AW'(i_id_rd);
        w_alu_nxt.we      = i_id_we;
        w_alu_nxt.is_load = i_id_is_load;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu       <= '0;
            r_dm        <= '0;
            r_wb        <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_alu <= w_alu_nxt;
            r_dm  <= r_alu;
            r_wb  <= r_dm;
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    fwd_mux #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_mux_a (
        .i_hit_alu (w_a_alu),
        .i_hit_dm  (w_a_dm),
        .i_hit_wb  (w_a_wb),
        .i_rf      (i_rf_rd1),
        .i_alu     (i_ex_result),
        .i_dm      (i_mem_result),
        .i_wb      (i_wb_result),
        .o_sel     (o_fwd_a_sel),
        .o_data    (o_opa)
    );

    fwd_mux #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_mux_b (
        .i_hit_alu (w_b_alu),
        .i_hit_dm  (w_b_dm),
        .i_hit_wb  (w_b_wb),
        .i_rf      (i_rf_rd2),
        .i_alu     (i_ex_result),
        .i_dm      (i_mem_result),
        .i_wb      (i_wb_result),
        .o_sel     (o_fwd_b_sel),
        .o_data    (o_opb)
    );

    assign o_stall     = w_stall;
    assign o_bubble    = w_stall;
    assign o_flush_if  = i_br_taken & i_id_valid & ~w_stall & ~reset;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: one forwarding and one stall-only instance share
// stimulus; each is compared against a history-list model of the pipeline.
module tb_hazard_fwd_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, rs1_used, rs2_used, id_we, id_ld, br_taken;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rf1, rf2, ex_res, mem_res, wb_res;

    logic [31:0] opa_o[2], opb_o[2], cnt_o[2];
    logic [1:0]  sela_o[2], selb_o[2];
    logic        stall_o[2], bub_o[2], flush_o[2];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.FWD_EN(1)) u_fwd (
        .clk(clk), .reset(reset), .i_id_valid(id_valid), .i_id_rs1_used(rs1_used),
        .i_id_rs2_used(rs2_used), .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rd(rd),
        .i_id_we(id_we), .i_id_is_load(id_ld), .i_br_taken(br_taken),
        .i_rf_rd1(rf1), .i_rf_rd2(rf2), .i_ex_result(ex_res), .i_mem_result(mem_res),
        .i_wb_result(wb_res), .o_opa(opa_o[0]), .o_opb(opb_o[0]),
        .o_fwd_a_sel(sela_o[0]), .o_fwd_b_sel(selb_o[0]), .o_stall(stall_o[0]),
        .o_bubble(bub_o[0]), .o_flush_if(flush_o[0]), .o_stall_cnt(cnt_o[0]));

    hazard_fwd_unit #(.FWD_EN(0)) u_nofwd (
        .clk(clk), .reset(reset), .i_id_valid(id_valid), .i_id_rs1_used(rs1_used),
        .i_id_rs2_used(rs2_used), .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rd(rd),
        .i_id_we(id_we), .i_id_is_load(id_ld), .i_br_taken(br_taken),
        .i_rf_rd1(rf1), .i_rf_rd2(rf2), .i_ex_result(ex_res), .i_mem_result(mem_res),
        .i_wb_result(wb_res), .o_opa(opa_o[1]), .o_opb(opb_o[1]),
        .o_fwd_a_sel(sela_o[1]), .o_fwd_b_sel(selb_o[1]), .o_stall(stall_o[1]),
        .o_bubble(bub_o[1]), .o_flush_if(flush_o[1]), .o_stall_cnt(cnt_o[1]));

    // hist[m][0] is the instruction issued last cycle (ALU), [1] DM, [2] WB.
    typedef struct {
        bit          v;
        int unsigned rd;
        bit          we;
        bit          ld;
    } ins_t;

    ins_t        hist[2][3];
    logic [31:0] cnt_m[2];

    function automatic bit writes(int m, int k, int unsigned src, bit used);
        return used && src != 0 && hist[m][k].v && hist[m][k].we && hist[m][k].rd == src;
    endfunction

    function automatic int exp_sel(int m, int unsigned src, bit used);
        if (reset || m == 1) return 0;
        for (int k = 0; k < 3; k++)
            if (writes(m, k, src, used)) return k + 1;
        return 0;
    endfunction

    function automatic bit exp_stall(int m);
        bit hit;
        if (reset || !id_valid) return 0;
        if (m == 0)
            return hist[0][0].ld && (writes(0, 0, rs1, rs1_used) || writes(0, 0, rs2, rs2_used));
        hit = 0;
        for (int k = 0; k < 3; k++)
            hit |= writes(1, k, rs1, rs1_used) || writes(1, k, rs2, rs2_used);
        return hit;
    endfunction

    function automatic logic [31:0] pick(int sel, logic [31:0] rf);
        case (sel)
            1:       return ex_res;
            2:       return mem_res;
            3:       return wb_res;
            default: return rf;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ins(bit v, int r1, bit u1, int r2, bit u2, int d, bit w, bit l);
        id_valid = v; rs1 = 5'(r1); rs1_used = u1; rs2 = 5'(r2); rs2_used = u2;
        rd = 5'(d); id_we = w; id_ld = l;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic check_model(input string tag);
        int sa, sb;
        bit st;
        string nm;
        for (int m = 0; m < 2; m++) begin
            nm = $sformatf("%s/%s", tag, (m == 0) ? "fwd" : "nofwd");
            sa = exp_sel(m, rs1, rs1_used);
            sb = exp_sel(m, rs2, rs2_used);
            st = exp_stall(m);
            chk({nm, ".stall"}, 32'(stall_o[m]), 32'(st));
            chk({nm, ".bubble"}, 32'(bub_o[m]), 32'(st));
            chk({nm, ".flush"}, 32'(flush_o[m]), 32'(br_taken && id_valid && !st && !reset));
            chk({nm, ".sel_a"}, 32'(sela_o[m]), 32'(sa));
            chk({nm, ".sel_b"}, 32'(selb_o[m]), 32'(sb));
            chk({nm, ".opa"}, opa_o[m], pick(sa, rf1));
            chk({nm, ".opb"}, opb_o[m], pick(sb, rf2));
            chk({nm, ".cnt"}, cnt_o[m], cnt_m[m]);
        end
    endtask

    task automatic advance();
        bit st[2];
        for (int m = 0; m < 2; m++) st[m] = exp_stall(m);
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                for (int k = 0; k < 3; k++) hist[m][k].v = 0;
                cnt_m[m] = '0;
            end else begin
                hist[m][2] = hist[m][1];
                hist[m][1] = hist[m][0];
                hist[m][0] = '{v: id_valid && !st[m], rd: rd, we: id_we, ld: id_ld};
                if (st[m] && cnt_m[m] != 32'hFFFF_FFFF) cnt_m[m] = cnt_m[m] + 1;
            end
        end
        #1;
    endtask

    task automatic step(input string tag);
        settle();
        check_model(tag);
        advance();
    endtask

    task automatic drain();
        set_ins(0, 0, 0, 0, 0, 0, 0, 0);
        br_taken = 0;
        for (int i = 0; i < 3; i++) step("drain");
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 3; k++) hist[m][k] = '{v: 0, rd: 0, we: 0, ld: 0};
            cnt_m[m] = '0;
        end
        reset = 1; br_taken = 0;
        set_ins(1, 1, 1, 2, 1, 3, 1, 0);
        rf1 = 32'h1111; rf2 = 32'h2222; ex_res = 32'hE0; mem_res = 32'hD0; wb_res = 32'hB0;
        @(posedge clk); #1;

        // reset: outputs quiet, operands straight from RF
        settle();
        check_model("reset");
        chk("reset.opa", opa_o[0], 32'h1111);
        chk("reset.stall", 32'(stall_o[0]), 0);
        advance();
        reset = 0;
        drain();

        // back-to-back RAW
        set_ins(1, 1, 1, 2, 1, 3, 1, 0);
        step("raw.add");
        set_ins(1, 3, 1, 1, 1, 4, 1, 0);
        ex_res = 32'h10;
        settle();
        check_model("raw.sub");
        chk("raw.sel_a", 32'(sela_o[0]), 1);
        chk("raw.opa", opa_o[0], 32'h10);
        chk("raw.stall", 32'(stall_o[0]), 0);
        advance();
        drain();

        // load-use
        set_ins(1, 1, 1, 0, 0, 5, 1, 1);
        step("lu.load");
        set_ins(1, 5, 1, 5, 1, 6, 1, 0);
        mem_res = 32'h55;
        settle();
        check_model("lu.stall");
        chk("lu.stall", 32'(stall_o[0]), 1);
        chk("lu.bubble", 32'(bub_o[0]), 1);
        advance();
        settle();
        check_model("lu.fwd");
        chk("lu.sel_a", 32'(sela_o[0]), 2);
        chk("lu.sel_b", 32'(selb_o[0]), 2);
        chk("lu.opa", opa_o[0], 32'h55);
        chk("lu.opb", opb_o[0], 32'h55);
        chk("lu.stall2", 32'(stall_o[0]), 0);
        advance();
        drain();

        // branch while load-use stalled
        set_ins(1, 0, 0, 0, 0, 9, 1, 1);
        step("br.load");
        set_ins(1, 9, 1, 0, 0, 10, 1, 0);
        br_taken = 1;
        settle();
        check_model("br.stalled");
        chk("br.flush_stalled", 32'(flush_o[0]), 0);
        advance();
        settle();
        check_model("br.free");
        chk("br.flush_free", 32'(flush_o[0]), 1);
        advance();
        drain();

        // r0 writer never forwards; youngest r7 writer wins
        set_ins(1, 0, 0, 0, 0, 0, 1, 0);
        step("r0.write");
        set_ins(1, 0, 1, 0, 1, 11, 0, 0);
        settle();
        check_model("r0.read");
        chk("r0.sel_a", 32'(sela_o[0]), 0);
        advance();
        drain();
        set_ins(1, 0, 0, 0, 0, 7, 1, 0); step("pri.w7a");
        set_ins(1, 0, 0, 0, 0, 8, 1, 0); step("pri.w8");
        set_ins(1, 0, 0, 0, 0, 7, 1, 0); step("pri.w7b");
        set_ins(1, 7, 1, 0, 0, 12, 0, 0);
        ex_res = 32'hA; wb_res = 32'hB;
        settle();
        check_model("pri.read");
        chk("pri.sel_a", 32'(sela_o[0]), 1);
        chk("pri.opa", opa_o[0], 32'hA);
        advance();
        drain();

        // reset in the middle of a load-use stall
        set_ins(1, 0, 0, 0, 0, 5, 1, 1);
        step("rst.load");
        set_ins(1, 5, 1, 0, 0, 6, 0, 0);
        reset = 1;
        settle();
        check_model("rst.during");
        chk("rst.stall", 32'(stall_o[0]), 0);
        advance();
        reset = 0;
        settle();
        check_model("rst.after");
        chk("rst.cnt", cnt_o[0], 0);
        chk("rst.cnt_nofwd", cnt_o[1], 0);
        chk("rst.no_stale", 32'(sela_o[0]), 0);
        advance();

        // stall-only instance: RAW distance 1 holds three cycles
        set_ins(1, 0, 0, 0, 0, 2, 1, 0);
        step("nf.add");
        set_ins(1, 2, 1, 0, 0, 13, 0, 0);
        for (int i = 0; i < 3; i++) begin
            settle();
            check_model("nf.held");
            chk("nf.stall", 32'(stall_o[1]), 1);
            advance();
        end
        settle();
        check_model("nf.release");
        chk("nf.stall_end", 32'(stall_o[1]), 0);
        chk("nf.sel_a", 32'(sela_o[1]), 0);
        chk("nf.cnt", cnt_o[1], 3);
        advance();

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            set_ins($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                    $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            br_taken = ($urandom_range(0, 4) == 0);
            rf1 = $urandom; rf2 = $urandom; ex_res = $urandom;
            mem_res = $urandom; wb_res = $urandom;
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
